// File: rtl/mux_arb_if.sv
// Bundle of the two requester ports and the shared selector outputs of mux_arb.
interface mux_arb_if #(
  parameter int unsigned DW = 8
);
  logic          req_a;
  logic          req_b;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          last_a;
  logic          last_b;
  logic          gnt_a;
  logic          gnt_b;
  logic          sel;
  logic [DW-1:0] y;
  logic          y_vld;
  logic          busy;

  modport master (
    output req_a, req_b, a, b, last_a, last_b,
    input  gnt_a, gnt_b, sel, y, y_vld, busy
  );

  modport slave (
    input  req_a, req_b, a, b, last_a, last_b,
    output gnt_a, gnt_b, sel, y, y_vld, busy
  );
endinterface

// File: rtl/mux_arb.sv
// Two-requester round-robin burst arbiter driving a registered shared selector.
// Optional macro MUX_ARB_TIMEOUT_EN: force release after MAX_HOLD beats when the other side waits.
module mux_arb #(
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic       clk,
  input logic       rst_n,
  mux_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("mux_arb: MAX_HOLD must be at least 1");
  end

  state_t        state;
  state_t        state_d;
  logic          last_owner;    // 1: B was granted most recently
  logic          last_owner_d;
  logic          sel_d;
  logic [DW-1:0] y_d;
  logic          y_vld_d;
  logic          granted;
  logic          own_req;
  logic          own_last;
  logic          oth_req;
  logic [DW-1:0] own_data;
  logic          tmo;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold;
  logic [CW-1:0] hold_d;

  // Counter sits at MAX_HOLD-1 before the beat that reaches MAX_HOLD
  assign tmo = own_req && oth_req && (hold >= CW'(MAX_HOLD - 1));
`else
  assign tmo = 1'b0;
`endif

  // Next state, selector and data path
  always_comb begin
    state_d      = state;
    last_owner_d = last_owner;
    sel_d        = bus.sel;
    y_d          = bus.y;
    y_vld_d      = 1'b0;
    granted      = 1'b0;
    own_req      = 1'b0;
    own_last     = 1'b0;
    oth_req      = 1'b0;
    own_data     = bus.a;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_d       = hold;
`endif

    unique case (state)
      IDLE: begin
        if (bus.req_a && (!bus.req_b || last_owner)) begin
          state_d = GNT_A;
        end else if (bus.req_b) begin
          state_d = GNT_B;
        end
      end
      GNT_A: begin
        granted  = 1'b1;
        own_req  = bus.req_a;
        own_last = bus.last_a;
        oth_req  = bus.req_b;
        own_data = bus.a;
      end
      GNT_B: begin
        granted  = 1'b1;
        own_req  = bus.req_b;
        own_last = bus.last_b;
        oth_req  = bus.req_a;
        own_data = bus.b;
      end
      default: state_d = IDLE;
    endcase

    if (granted) begin
      if (own_req) begin
        y_d     = own_data;
        y_vld_d = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
        if (hold != CW'(MAX_HOLD)) begin
          hold_d = hold + CW'(1);
        end
`endif
      end
      // Abort (req dropped), last beat, or forced release; hand straight over if the other side waits
      if (!own_req || own_last || tmo) begin
        if (oth_req) begin
          state_d = (state == GNT_A) ? GNT_B : GNT_A;
        end else begin
          state_d = IDLE;
        end
      end
    end

    if ((state_d != state) && (state_d != IDLE)) begin
      last_owner_d = (state_d == GNT_B);
      sel_d        = (state_d == GNT_B);
`ifdef MUX_ARB_TIMEOUT_EN
      hold_d       = '0;
`endif
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      bus.gnt_a  <= 1'b0;
      bus.gnt_b  <= 1'b0;
      bus.busy   <= 1'b0;
      bus.sel    <= 1'b0;
      bus.y      <= '0;
      bus.y_vld  <= 1'b0;
    end else begin
      state      <= state_d;
      last_owner <= last_owner_d;
      bus.gnt_a  <= (state_d == GNT_A);
      bus.gnt_b  <= (state_d == GNT_B);
      bus.busy   <= (state_d != IDLE);
      bus.sel    <= sel_d;
      bus.y      <= y_d;
      bus.y_vld  <= y_vld_d;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else begin
      hold <= hold_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: directed scenarios plus random traffic against an owner-level model.
module tb_mux_arb;
  localparam int unsigned DW       = 8;
  localparam int unsigned MAX_HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mux_arb_if #(.DW(DW)) bus ();

  mux_arb #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-cycle expected {gnt_a, gnt_b, sel, busy, y_vld}, and expected data of each beat
  logic [4:0]    st_q[$];
  logic [DW-1:0] dat_q[$];

  // Model: owner 0 = none, 1 = A, 2 = B
  int   owner;
  int   mlast;
  int   mhold;
  logic msel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = 0;
    mlast = 2;
    mhold = 0;
    msel  = 1'b0;
  endtask

  // Predict what the next rising edge produces for the given inputs
  task automatic model_step(input bit ra, input bit la, input logic [DW-1:0] da,
                            input bit rb, input bit lb, input logic [DW-1:0] db);
    int nxt;
    bit beat;
    bit r;
    bit l;
    bit ro;
    logic [DW-1:0] d;
    nxt  = owner;
    beat = 1'b0;
    if (owner == 0) begin
      if (ra && rb) nxt = (mlast == 2) ? 1 : 2;
      else if (ra)  nxt = 1;
      else if (rb)  nxt = 2;
    end else begin
      r  = (owner == 1) ? ra : rb;
      l  = (owner == 1) ? la : lb;
      ro = (owner == 1) ? rb : ra;
      d  = (owner == 1) ? da : db;
      if (r) begin
        beat = 1'b1;
        dat_q.push_back(d);
        if (mhold < int'(MAX_HOLD)) mhold++;
      end
      if (!r || l || (TMO && r && ro && mhold >= int'(MAX_HOLD)))
        nxt = ro ? (3 - owner) : 0;
    end
    if (nxt != owner && nxt != 0) begin
      mlast = nxt;
      msel  = (nxt == 2);
      mhold = 0;
    end
    owner = nxt;
    st_q.push_back({owner == 1, owner == 2, msel, owner != 0, beat});
  endtask

  // One clock of stimulus, driven on the falling edge
  task automatic cycle(input bit ra, input bit la, input logic [DW-1:0] da,
                       input bit rb, input bit lb, input logic [DW-1:0] db);
    @(negedge clk);
    rst_n      = 1'b1;
    bus.req_a  = ra;
    bus.last_a = la;
    bus.a      = da;
    bus.req_b  = rb;
    bus.last_b = lb;
    bus.b      = db;
    model_step(ra, la, da, rb, lb, db);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    bus.req_a  = 1'b0;
    bus.req_b  = 1'b0;
    bus.last_a = 1'b0;
    bus.last_b = 1'b0;
    st_q.delete();
    dat_q.delete();
    model_reset();
    #1;
    check("reset_outputs",
          32'({bus.gnt_a, bus.gnt_b, bus.sel, bus.busy, bus.y_vld, bus.y}), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare status every active cycle, and beat data whenever y_vld is presented
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (st_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL status_underflow: no expected entry at %0t", $time);
      end else begin
        check("status_gnta_gntb_sel_busy_vld",
              32'({bus.gnt_a, bus.gnt_b, bus.sel, bus.busy, bus.y_vld}),
              32'(st_q.pop_front()));
      end
      if (bus.y_vld) begin
        if (dat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL y_unexpected: got %0h with no beat expected at %0t", bus.y, $time);
        end else begin
          check("y_data", 32'(bus.y), 32'(dat_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bus.req_a  = 1'b0;
    bus.req_b  = 1'b0;
    bus.last_a = 1'b0;
    bus.last_b = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    model_reset();
    do_reset();

    // Single beat from A
    cycle(1, 1, 8'h11, 0, 0, 8'h00);
    cycle(0, 0, 8'h00, 0, 0, 8'h00);
    repeat (2) cycle(0, 0, 8'h00, 0, 0, 8'h00);

    // Contention: A two beats, B waiting, direct handover
    cycle(1, 0, 8'h21, 1, 0, 8'h31);
    cycle(1, 0, 8'h22, 1, 0, 8'h31);
    cycle(1, 1, 8'h23, 1, 0, 8'h32);
    cycle(0, 0, 8'h00, 1, 1, 8'h33);
    repeat (2) cycle(0, 0, 8'h00, 0, 0, 8'h00);

    // Alternating single-beat requests
    repeat (8) cycle(1, 1, 8'hAA, 1, 1, 8'hBB);
    repeat (2) cycle(0, 0, 8'h00, 0, 0, 8'h00);

    // B drops mid-burst
    cycle(0, 0, 8'h00, 1, 0, 8'h41);
    cycle(0, 0, 8'h00, 1, 0, 8'h42);
    cycle(0, 0, 8'h00, 1, 0, 8'h43);
    cycle(0, 0, 8'h00, 0, 0, 8'h44);
    repeat (2) cycle(0, 0, 8'h00, 0, 0, 8'h00);

    // Reset during A's third beat, then contention must favour A
    cycle(1, 0, 8'h51, 0, 0, 8'h00);
    cycle(1, 0, 8'h52, 0, 0, 8'h00);
    cycle(1, 0, 8'h53, 0, 0, 8'h00);
    cycle(1, 0, 8'h54, 0, 0, 8'h00);
    do_reset();
    cycle(1, 1, 8'h61, 1, 1, 8'h71);
    cycle(1, 1, 8'h62, 1, 1, 8'h72);
    cycle(0, 0, 8'h00, 1, 1, 8'h73);
    repeat (2) cycle(0, 0, 8'h00, 0, 0, 8'h00);

    // A streams ten beats while B keeps requesting
    for (int i = 0; i < 11; i++)
      cycle(1, (i == 10), 8'(8'h80 + i), 1, 1, 8'hC0);
    repeat (12) cycle(1, 1, 8'h9F, 1, 1, 8'hC1);
    repeat (2) cycle(0, 0, 8'h00, 0, 0, 8'h00);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom));

    repeat (4) cycle(0, 0, 8'h00, 0, 0, 8'h00);
    @(posedge clk);
    #2;
    check("status_drained", 32'(st_q.size()), 32'd0);
    check("data_drained", 32'(dat_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter DW, default 8, data width of each requester and of the output.
REQ-002 Parameter MAX_HOLD, default 4, maximum granted beats before forced release (used only with MUX_ARB_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_a / req_b  input  1  requester A / B wants the shared selector; one beat transfers per cycle while high and granted.
REQ-006 a / b  input  DW  requester A / B data, sampled only on that requester's granted beats.
REQ-007 last_a / last_b  input  1  final beat of the current A / B burst, qualified by req_x and gnt_x.
REQ-008 gnt_a / gnt_b  output  1  registered grant; never both high.
REQ-009 sel  output  1  registered selector: 0 routes a, 1 routes b.
REQ-010 y  output  DW  registered selected data.
REQ-011 y_vld  output  1  y holds a beat captured on the previous edge.
REQ-012 busy  output  1  high whenever gnt_a or gnt_b is high.

Function
REQ-013 FSM states IDLE, GNT_A, GNT_B; exactly one state active.
REQ-014 Beat: cycle in GNT_x with req_x=1; at its edge y<=x data, y_vld<=1; in any other cycle y_vld<=0 and y holds.
REQ-015 Latency: req_x rises in IDLE at edge N -> gnt_x=1 after edge N+1; first beat lands y/y_vld after edge N+2.
REQ-016 IDLE arbitration: one request -> grant it; both -> round-robin, grant the requester not most recently granted (last_owner register).
REQ-017 last_owner updates to x on every entry to GNT_x; reset value B, so A wins first contention.
REQ-018 Release from GNT_x on a beat with last_x=1, or on any cycle with req_x=0 (abort, no beat).
REQ-019 On release, if the other requester's req is high that cycle -> next state GNT_other (direct handover, zero idle cycles); else -> IDLE.
REQ-020 Same requester never re-granted directly from its own release; it re-enters only via IDLE.
REQ-021 sel<=0 on entry to GNT_A, 1 on entry to GNT_B; sel holds its value in IDLE.
REQ-022 gnt_x/sel/y always consistent: a beat captured while gnt_a=1 carries a, never b.
REQ-023 last_x ignored when req_x=0 or gnt_x=0.

Reset
REQ-024 rst_n low asynchronously forces: state IDLE, gnt_a=0, gnt_b=0, sel=0, y=0, y_vld=0, busy=0, last_owner=B, hold counter=0.
REQ-025 Reset mid-burst discards the burst; after deassert, arbitration restarts from IDLE with A preferred.

Configuration
REQ-026 Macro MUX_ARB_TIMEOUT_EN defined: hold counter counts granted beats, cleared on each grant entry; on the beat where count reaches MAX_HOLD and the other req is high, release as in REQ-019 even without last_x.
REQ-027 Forced release does not end the preempted burst: requester keeps req high and is re-granted per REQ-016/REQ-019 later.
REQ-028 Count saturates at MAX_HOLD; no release if the other req is low.
REQ-029 Macro undefined: no counter logic, grant held until last_x or req_x=0.

Verification
REQ-030 Reset then req_a=1, a=8'h11, last_a=1 single beat -> gnt_a after 1 edge, y=8'h11 with y_vld=1 one edge later, return to IDLE, sel=0.
REQ-031 req_a and req_b rise together after reset -> A granted first; A bursts 2 beats (last on 2nd), B held high -> gnt_b rises the edge after A's last beat, sel=1, no idle cycle.
REQ-032 Repeated simultaneous single-beat requests -> grants alternate A,B,A,B; y alternates a/b values (e.g. 8'hAA/8'hBB).
REQ-033 req_b drops mid-burst without last_b -> gnt_b falls next edge, no y_vld for the dropped cycle.
REQ-034 rst_n pulled low mid-burst of A (3rd beat) -> all outputs 0 immediately; after release, contention grants A first.
REQ-035 With MUX_ARB_TIMEOUT_EN, MAX_HOLD=4: A streams 10 beats with B requesting -> A released after 4th beat, B granted; without macro A keeps grant for all 10 beats.
